mau_operand_feeder: RTL

//  Upstream operand stage for TOP_MAU in the Dilithium SCA target.
//  The host loads a batch of (a,b) coefficient pairs over the local bus.
//  On a start pulse (blk_drdy) the block emits a trigger, replays the batch
//  one pair per cycle into the MAU with enable high, then holds enable

---
 rtl/mau_operand_feeder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mau_operand_feeder.sv
// Operand replay stage for the MAU: buffers (a,b) pairs from the host and replays them
// with a scope trigger, a pre-roll gap and an enable-high drain tail on every start.
module mau_operand_feeder #(
    parameter int DATA_W      = 24,
    parameter int DEPTH       = 8,
    parameter int PRE_CYCLES  = 2,
    parameter int POST_CYCLES = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_a,
    input  logic [DATA_W-1:0]          wr_b,
    input  logic                       clr,
    input  logic                       start,
    output logic [DATA_W-1:0]          a,
    output logic [DATA_W-1:0]          b,
    output logic                       enable,
    output logic                       trig,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PH_MAX = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    typedef enum logic [1:0] {IDLE, PRE, RUN, POST} state_t;

    state_t             state_reg, state_next;
    logic [PH_W-1:0]    phase_reg, phase_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               trig_reg, trig_next;
    logic               done_reg, done_next;
    logic               enable_reg, enable_next;
    logic [CNT_W-1:0]   count_reg;
    logic               err_reg;
    logic [DATA_W-1:0]  a_reg, b_reg;

    logic [DATA_W-1:0]  mem_a [DEPTH];
    logic [DATA_W-1:0]  mem_b [DEPTH];

    logic idle, go, wr_ok, clr_ok, err_set, last_pair;

    // Command arbitration: clr beats start, start beats wr_en; only IDLE accepts commands.
    assign idle    = (state_reg == IDLE);
    assign clr_ok  = idle && clr;
    assign go      = idle && !clr && start && (count_reg != '0);
    assign wr_ok   = idle && !clr && !start && wr_en && (count_reg < CNT_W'(DEPTH));
    assign err_set = (!idle && (wr_en || clr))
                   || (idle && !clr && ((start && count_reg == '0)
                                        || (wr_en && (start || count_reg == CNT_W'(DEPTH)))));
    assign last_pair = ((CNT_W'(idx_reg) + CNT_W'(1)) == count_reg);

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        idx_next   = idx_reg;
        trig_next  = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (go) begin
                    state_next = PRE;
                    phase_next = PH_W'(PRE_CYCLES - 1);
                    trig_next  = 1'b1;
                end
            end
            PRE: begin
                if (phase_reg == '0) begin
                    state_next = RUN;
                    idx_next   = '0;
                end else begin
                    phase_next = phase_reg - PH_W'(1);
                end
            end
            RUN: begin
                if (last_pair) begin
                    if (POST_CYCLES > 0) begin
                        state_next = POST;
                        phase_next = PH_W'(POST_CYCLES - 1);
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            POST: begin
                if (phase_reg == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    phase_next = phase_reg - PH_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        enable_next = (state_next == RUN) || (state_next == POST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            phase_reg  <= '0;
            idx_reg    <= '0;
            trig_reg   <= 1'b0;
            done_reg   <= 1'b0;
            enable_reg <= 1'b0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            idx_reg    <= idx_next;
            trig_reg   <= trig_next;
            done_reg   <= done_next;
            enable_reg <= enable_next;
            if (clr_ok)
                count_reg <= '0;
            else if (wr_ok)
                count_reg <= count_reg + CNT_W'(1);
            if (clr_ok)
                err_reg <= 1'b0;
            else if (err_set)
                err_reg <= 1'b1;
        end
    end

    // Buffer storage; the read port is registered and forced to zero outside RUN.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_a[IDX_W'(count_reg)] <= wr_a;
            mem_b[IDX_W'(count_reg)] <= wr_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (state_next == RUN) begin
            a_reg <= mem_a[idx_next];
            b_reg <= mem_b[idx_next];
        end else begin
            a_reg <= '0;
            b_reg <= '0;
        end
    end

    assign a      = a_reg;
    assign b      = b_reg;
    assign enable = enable_reg;
    assign trig   = trig_reg;
    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;
    assign count  = count_reg;
    assign err    = err_reg;
endmodule
